// File: rtl/raccoon_pkg.sv
// Raccoon ring definitions shared by ring nodes.
// Holds the ring word field positions, the slot type codes, the initiator
// state encoding and a helper that assembles a request word.
package raccoon_pkg;

    // Ring word field positions
    localparam int unsigned TYPE_HI = 63;
    localparam int unsigned TYPE_LO = 62;
    localparam int unsigned ID_HI   = 61;
    localparam int unsigned ID_LO   = 55;
    localparam int unsigned SEQ_BIT = 54;
    localparam int unsigned MASK_HI = 53;
    localparam int unsigned MASK_LO = 50;
    localparam int unsigned ADDR_HI = 49;
    localparam int unsigned ADDR_LO = 32;
    localparam int unsigned DATA_HI = 31;
    localparam int unsigned DATA_LO = 0;

    // Slot type codes
    localparam logic [1:0] RACC_EMPTY = 2'b00;
    localparam logic [1:0] RACC_REQ   = 2'b11;
    localparam logic [1:0] RACC_RSP   = 2'b10;

    // Initiator states: idle, waiting for an empty slot, waiting for a response
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPend = 2'd1,
        StWait = 2'd2
    } state_e;

    function automatic logic [63:0] racc_req_word(input logic [6:0]  id,
                                                  input logic        seq,
                                                  input logic [3:0]  mask,
                                                  input logic [17:0] addr,
                                                  input logic [31:0] data);
        logic [63:0] w;
        w                   = '0;
        w[TYPE_HI:TYPE_LO]  = RACC_REQ;
        w[ID_HI:ID_LO]      = id;
        w[SEQ_BIT]          = seq;
        w[MASK_HI:MASK_LO]  = mask;
        w[ADDR_HI:ADDR_LO]  = addr;
        w[DATA_HI:DATA_LO]  = data;
        return w;
    endfunction

endpackage

// File: rtl/ram2raccoon.sv
// Initiator end of the Raccoon ring.
// Turns one RAM-style request (read or masked write) into a ring request word,
// inserts it into the first empty slot, then pulls the matching response off
// the ring. All other traffic passes through with a 2-cycle latency.
//   CLK, RST          clock, synchronous active-high reset
//   RaccIn / RaccOut  ring word from upstream / to downstream
//   REQ, WE, ADDR, MASK, WR_DATA   local request (REQ taken only when idle)
//   BUSY              transaction in flight
//   DONE / ERR        one-cycle completion / failure pulses
//   RD_DATA           response data, held until the next DONE
module ram2raccoon
    import raccoon_pkg::*;
#(
    parameter logic [6:0]  MASTER_ID = 7'h01,
    parameter logic [15:0] TIMEOUT   = 16'd1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [63:0] RaccIn,
    output logic [63:0] RaccOut,
    input  logic        REQ,
    input  logic        WE,
    input  logic [19:0] ADDR,
    input  logic [3:0]  MASK,
    input  logic [31:0] WR_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] RD_DATA
);

    state_e      state_q, state_d;
    logic [63:0] din_q, dout_q, dout_d;
    logic        seq_q, seq_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  mask_q, mask_d;
    logic [17:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [1:0] din_type;
    logic       tag;
    logic       id_hit, seq_hit, our_rsp, match_rsp, own_req, timed_out;

    // Byte offset is not carried on the ring
    logic unused_addr_lo;
    assign unused_addr_lo = ^ADDR[1:0];

    // seq_q flips on every acceptance starting from 0, so the transaction in
    // flight is tagged with its complement: the first request carries 0.
    assign tag       = ~seq_q;
    assign din_type  = din_q[TYPE_HI:TYPE_LO];
    assign id_hit    = (din_q[ID_HI:ID_LO] == MASTER_ID);
    assign seq_hit   = (din_q[SEQ_BIT] == tag);
    assign our_rsp   = (din_type == RACC_RSP) && id_hit;
    assign match_rsp = our_rsp && seq_hit;
    assign own_req   = (din_type == RACC_REQ) && id_hit && seq_hit;
    assign timed_out = (TIMEOUT != 16'd0) && (16'(timer_q + 16'd1) == TIMEOUT);

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        timer_d   = timer_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        dout_d    = din_q;

        if (state_q != StIdle) begin
            timer_d = 16'(timer_q + 16'd1);
        end

        unique case (state_q)
            StIdle: begin
                if (our_rsp) begin
                    dout_d = '0;
                end
                if (REQ) begin
                    mask_d  = WE ? MASK : 4'h0;
                    addr_d  = ADDR[19:2];
                    wdata_d = WR_DATA;
                    seq_d   = ~seq_q;
                    timer_d = '0;
                    state_d = StPend;
                end
            end
            StPend: begin
                if (timed_out) begin
                    // Give up before inserting; the slot is left alone
                    if (our_rsp) begin
                        dout_d = '0;
                    end
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (din_type == RACC_EMPTY) begin
                    dout_d  = racc_req_word(MASTER_ID, tag, mask_q, addr_q, wdata_q);
                    state_d = StWait;
                end else if (our_rsp) begin
                    dout_d = '0;
                end
            end
            StWait: begin
                // A matching response beats a timeout in the same cycle
                if (match_rsp) begin
                    dout_d    = '0;
                    rd_data_d = din_q[DATA_HI:DATA_LO];
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end else if (own_req) begin
                    // Request went all the way round unclaimed
                    dout_d  = '0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    if (our_rsp) begin
                        dout_d = '0;
                    end
                    if (timed_out) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            din_q     <= '0;
            dout_q    <= '0;
            seq_q     <= 1'b0;
            timer_q   <= '0;
            mask_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            din_q     <= RaccIn;
            dout_q    <= dout_d;
            seq_q     <= seq_d;
            timer_q   <= timer_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign RaccOut = dout_q;
    assign BUSY    = (state_q != StIdle);
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign RD_DATA = rd_data_q;

endmodule
